// File: rtl/gf_power_engine.sv
// ============================================================================
// Module  : gf_power_engine
// Brief   : Multi-lane iterative y = x^E over GF(2^N), left-to-right
//           square-and-multiply, one exponent bit per clock.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gf_power_engine #(
   parameter int         N     = 6,
   parameter logic [N:0] POLY  = 7'h43,
   parameter int         LANES = 4,
   parameter int         EXP_W = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [EXP_W-1:0]     in_exp,
   input  logic [LANES*N-1:0]   in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [LANES*N-1:0]   out_data,
   output logic                 busy
);

   localparam int                 c_IDX_W    = (EXP_W > 1) ? $clog2(EXP_W) : 1;
   localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(EXP_W - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;
   logic                   r_live;
   logic [LANES*N-1:0]     r_x;
   logic [LANES*N-1:0]     r_acc;
   logic [EXP_W-1:0]       r_exp;
   logic [c_IDX_W-1:0]     r_idx;
   logic                   r_out_valid;
   logic [LANES*N-1:0]     r_out_data;
   logic [LANES*N-1:0]     w_acc_nxt;
   logic                   w_accept;
   logic                   w_last;

   function automatic logic [N-1:0] gf_xtime(input logic [N-1:0] a);
      gf_xtime = (a << 1) ^ (a[N-1] ? POLY[N-1:0] : '0);
   endfunction

   // MSB-first Horner product: reduction is folded into every doubling step.
   function automatic logic [N-1:0] gf_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [N-1:0] p;
      p = '0;
      for (int i = N - 1; i >= 0; i--) begin
         p = gf_xtime(p) ^ (b[i] ? a : '0);
      end
      gf_mul = p;
   endfunction

   for (genvar k = 0; k < LANES; k++) begin : g_lane
      logic [N-1:0] w_sq;
      assign w_sq = gf_mul(r_acc[k*N +: N], r_acc[k*N +: N]);
      assign w_acc_nxt[k*N +: N] = r_exp[EXP_W-1] ? gf_mul(w_sq, r_x[k*N +: N]) : w_sq;
   end

   assign in_ready  = r_live && (r_state == S_IDLE);
   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_state == S_RUN) && (r_idx == '0);
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign busy      = (r_state == S_RUN) || (r_state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
         S_RUN:   if (r_idx == '0) w_state_nxt = S_DONE;
         S_DONE:  if (r_out_valid && out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // r_live holds in_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_live      <= 1'b0;
         r_x         <= '0;
         r_acc       <= '0;
         r_exp       <= '0;
         r_idx       <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_live <= 1'b1;
         if (w_accept) begin
            r_x   <= in_data;
            r_exp <= in_exp;
            r_idx <= c_IDX_LAST;
            for (int k = 0; k < LANES; k++) begin
               r_acc[k*N +: N] <= N'(1);
            end
         end else if (r_state == S_RUN) begin
            r_acc <= w_acc_nxt;
            r_exp <= r_exp << 1;
            r_idx <= r_idx - 1'b1;
            if (w_last) begin
               r_out_valid <= 1'b1;
               r_out_data  <= w_acc_nxt;
            end
         end else if ((r_state == S_DONE) && r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gf_power_engine.sv
// ============================================================================
// Module  : tb_gf_power_engine
// Brief   : Vector table, corner sequences and random ops vs. a power model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gf_power_engine;

   localparam int         N     = 6;
   localparam int         LANES = 4;
   localparam int         EXP_W = 6;
   localparam logic [N:0] POLY  = 7'h43;
   localparam int         DW    = LANES * N;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b0;
   logic            in_valid  = 1'b0;
   logic            in_ready;
   logic [EXP_W-1:0] in_exp   = '0;
   logic [DW-1:0]   in_data   = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [DW-1:0]   out_data;
   logic            busy;

   int checks   = 0;
   int failures = 0;

   gf_power_engine #(.N(N), .POLY(POLY), .LANES(LANES), .EXP_W(EXP_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_exp    (in_exp),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [EXP_W-1:0] e;
      logic [DW-1:0]    d;
      logic [DW-1:0]    q;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Schoolbook carry-less product, then long division by POLY.
   function automatic logic [N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
      logic [2*N-2:0] p, aa, pp;
      p  = '0;
      aa = '0;
      pp = '0;
      aa[N-1:0] = a;
      pp[N:0]   = POLY;
      for (int i = 0; i < N; i++) if (b[i]) p ^= aa << i;
      for (int i = 2*N-2; i >= N; i--) if (p[i]) p ^= pp << (i - N);
      return p[N-1:0];
   endfunction

   function automatic logic [N-1:0] ref_pow(input logic [N-1:0] x, input int e);
      logic [N-1:0] r;
      r = N'(1);
      for (int i = 0; i < e; i++) r = ref_mul(r, x);
      return r;
   endfunction

   function automatic logic [DW-1:0] ref_vec(input logic [DW-1:0] d, input int e);
      logic [DW-1:0] q;
      q = '0;
      for (int k = 0; k < LANES; k++) q[k*N +: N] = ref_pow(d[k*N +: N], e);
      return q;
   endfunction

   task automatic start_op(input logic [EXP_W-1:0] e, input logic [DW-1:0] d);
      int          n;
      logic [31:0] junk;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_exp   = e;
      in_data  = d;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'(in_ready), 64'(1));
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      junk     = $urandom;
      in_exp   = junk[EXP_W-1:0];
      in_data  = junk[DW-1:0];
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input logic [EXP_W-1:0] e, input logic [DW-1:0] d, output logic [DW-1:0] q);
      int lat;
      out_ready = 1'b1;
      start_op(e, d);
      wait_valid(lat);
      chk("latency", 64'(lat), 64'(EXP_W));
      q = out_data;
      @(posedge clk);
      #1;
      chk("idle_after_pop", 64'({in_ready, out_valid, busy, out_data}), 64'({1'b1, 1'b0, 1'b0, {DW{1'b0}}}));
   endtask

   initial begin
      vec_t          tbl[8];
      logic [DW-1:0] q, exp_q, hold;
      logic [31:0]   r0;
      logic [N-1:0]  xl;
      int            lat, errs;

      tbl[0] = '{e: 6'd26, d: {6'h02, 6'h02, 6'h02, 6'h02}, q: {6'h07, 6'h07, 6'h07, 6'h07}};
      tbl[1] = '{e: 6'd1,  d: {6'h03, 6'h2A, 6'h00, 6'h3F}, q: {6'h03, 6'h2A, 6'h00, 6'h3F}};
      tbl[2] = '{e: 6'd62, d: {6'h21, 6'h01, 6'h00, 6'h02}, q: {6'h02, 6'h01, 6'h00, 6'h21}};
      tbl[3] = '{e: 6'd63, d: {6'h00, 6'h21, 6'h01, 6'h02}, q: {6'h00, 6'h01, 6'h01, 6'h01}};
      tbl[4] = '{e: 6'd0,  d: {6'h15, 6'h3F, 6'h02, 6'h00}, q: {6'h01, 6'h01, 6'h01, 6'h01}};
      tbl[5] = '{e: 6'd5,  d: {6'h00, 6'h00, 6'h00, 6'h00}, q: {6'h00, 6'h00, 6'h00, 6'h00}};
      tbl[6] = '{e: 6'd2,  d: {6'h00, 6'h20, 6'h03, 6'h02}, q: {6'h00, 6'h30, 6'h05, 6'h04}};
      tbl[7] = '{e: 6'd3,  d: {6'h01, 6'h00, 6'h02, 6'h02}, q: {6'h01, 6'h00, 6'h08, 6'h08}};

      // Reset state
      #12;
      chk("reset_outputs", 64'({in_ready, out_valid, busy, out_data}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("ready_after_reset", 64'(in_ready), 64'(1));

      foreach (tbl[i]) begin
         run_op(tbl[i].e, tbl[i].d, q);
         chk($sformatf("vector_%0d", i), 64'(q), 64'(tbl[i].q));
      end

      // Back-pressure: result held stable while out_ready is low
      out_ready = 1'b0;
      start_op(6'd26, {4{6'h02}});
      wait_valid(lat);
      chk("stall_latency", 64'(lat), 64'(EXP_W));
      hold = out_data;
      chk("stall_value", 64'(hold), 64'({4{6'h07}}));
      for (int c = 0; c < 10; c++) begin
         chk("stall_hold", 64'({out_valid, in_ready, busy, out_data}), 64'({1'b1, 1'b0, 1'b1, hold}));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release", 64'({in_ready, out_valid, out_data}), 64'({1'b1, 1'b0, {DW{1'b0}}}));

      // Request held during RUN is deferred, then taken with its own exponent
      start_op(6'd26, {4{6'h02}});
      in_valid = 1'b1;
      in_exp   = 6'd3;
      in_data  = {4{6'h02}};
      lat  = 0;
      errs = 0;
      while (!out_valid && lat < 50) begin
         if (in_ready) errs++;
         @(posedge clk);
         #1;
         lat++;
      end
      chk("holdoff_ready_low", 64'(errs), 64'(0));
      chk("holdoff_first", 64'({in_ready, out_data}), 64'({1'b0, {4{6'h07}}}));
      @(posedge clk);
      #1;
      chk("holdoff_idle_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      wait_valid(lat);
      chk("holdoff_latency", 64'(lat), 64'(EXP_W));
      chk("holdoff_second", 64'(out_data), 64'({4{6'h08}}));
      @(posedge clk);
      #1;

      // Asynchronous reset in the 3rd RUN cycle
      start_op(6'd26, {4{6'h02}});
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrun_reset", 64'({out_valid, busy, in_ready, out_data}), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      errs = 0;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         if (out_valid || busy) errs++;
      end
      chk("no_result_after_reset", 64'(errs), 64'(0));
      run_op(6'd26, {4{6'h02}}, q);
      chk("after_reset_op", 64'(q), 64'({4{6'h07}}));

      // Random operands and exponents against the repeated-product model
      for (int t = 0; t < 2000; t++) begin
         r0 = $urandom;
         lat = int'($urandom_range(0, 63));
         exp_q = ref_vec(r0[DW-1:0], lat);
         run_op(EXP_W'(lat), r0[DW-1:0], q);
         chk("random_op", 64'(q), 64'(exp_q));
      end

      // Inverse property: x^(2^N-2) * x = 1 for nonzero x
      for (int t = 0; t < 200; t++) begin
         for (int k = 0; k < LANES; k++) begin
            xl = N'($urandom_range(1, 63));
            in_data[k*N +: N] = xl;
            hold[k*N +: N]    = xl;
         end
         run_op(6'd62, hold, q);
         errs = 0;
         for (int k = 0; k < LANES; k++) begin
            if (ref_mul(q[k*N +: N], hold[k*N +: N]) != N'(1)) errs++;
         end
         chk("inverse_product", 64'(errs), 64'(0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
